// File: rtl/hilo_mul_ctrl.sv
// hilo_mul_ctrl
// Multiply-unit controller for the HI/LO datapath. Registers operands onto an
// external combinational 32x32 signed multiplier, holds them for LATENCY
// cycles, then commits the (corrected / accumulated) product into HI/LO.
//
// Ports:
//   clk     - sole clock, rising edge
//   reset   - asynchronous, active-low
//   start   - one-cycle request from EX, sampled only in IDLE
//   op      - 000 MULT, 001 MULTU, 010 MADD, 011 MSUB, 100 MTHI, 101 MTLO
//   rs_val  - operand A / MTHI-MTLO source
//   rt_val  - operand B
//   flush   - kill any accepted, uncommitted multiply
//   mul_a   - registered operand A to multiplier
//   mul_b   - registered operand B to multiplier
//   mul_z   - signed 64-bit product from multiplier
//   busy    - high while a multiply is in flight
//   done    - one-cycle pulse after a multiply commits
//   hi, lo  - architectural HI / LO
module hilo_mul_ctrl #(
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_z,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_MADD  = 3'b010,
    OP_MSUB  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY);

  state_t      state;
  op_t         op_q;
  logic [3:0]  count;
  logic [31:0] corr;
  logic [63:0] result;

  // Signed-to-unsigned fix-up: a negative-as-signed operand contributes the
  // other operand times 2^32; only the low 32 bits of the sum survive the
  // shift into the upper word mod 2^64.
  always_comb begin
    corr   = (mul_a[31] ? mul_b : 32'd0) + (mul_b[31] ? mul_a : 32'd0);
    result = mul_z;
    case (op_q)
      OP_MULT:  result = mul_z;
      OP_MULTU: result = mul_z + {corr, 32'd0};
      OP_MADD:  result = {hi, lo} + mul_z;
      OP_MSUB:  result = {hi, lo} - mul_z;
      default:  result = mul_z;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      op_q  <= OP_MULT;
      count <= '0;
      mul_a <= '0;
      mul_b <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            case (op)
              OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                mul_a <= rs_val;
                mul_b <= rt_val;
                op_q  <= op_t'(op);
                count <= CNT_INIT;
                busy  <= 1'b1;
                state <= WAIT;
              end
              OP_MTHI: hi <= rs_val;
              OP_MTLO: lo <= rs_val;
              default: ;
            endcase
          end
        end
        WAIT: begin
          if (flush) begin
            count <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (count == 4'd1) begin
            {hi, lo} <= result;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= IDLE;
          end else begin
            count <= count - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Self-checking bench for hilo_mul_ctrl: directed cases plus randomized
// operation mix, compared against an arithmetic reference of HI/LO.
module tb_hilo_mul_ctrl;

  localparam int unsigned LAT = 3;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_z;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [63:0] m_hilo;

  hilo_mul_ctrl #(.LATENCY(LAT)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .flush  (flush),
    .mul_a  (mul_a),
    .mul_b  (mul_b),
    .mul_z  (mul_z),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  // External combinational signed multiplier.
  assign mul_z = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: true signed/unsigned 64-bit products, plain accumulate.
  function automatic logic [63:0] ref_commit(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
    logic [63:0] sa, sb, ps, pu;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ps = sa * sb;
    pu = {32'd0, a} * {32'd0, b};
    case (o)
      3'd0:    return ps;
      3'd1:    return pu;
      3'd2:    return acc + ps;
      3'd3:    return acc - ps;
      default: return acc;
    endcase
  endfunction

  // fl = 0: no flush; otherwise flush asserted during cycle T+fl.
  task automatic run_mul(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int unsigned fl, input bit spur);
    op = o; rs_val = a; rt_val = b; flush = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("mul_a_latch", mul_a, a);
    check("mul_b_latch", mul_b, b);
    for (int unsigned k = 1; k <= LAT; k++) begin
      check("busy_wait", busy, 1);
      check("done_wait", done, 0);
      start = spur && (k == 1);
      if (start) begin
        rs_val = $urandom;
        rt_val = $urandom;
      end
      flush = (k == fl);
      tick();
      start = 1'b0;
      if (k == fl) begin
        flush = 1'b0;
        check("busy_flush", busy, 0);
        check("done_flush", done, 0);
        check("hilo_flush", {hi, lo}, m_hilo);
        tick();
        check("busy_after_flush", busy, 0);
        check("done_after_flush", done, 0);
        check("hilo_after_flush", {hi, lo}, m_hilo);
        return;
      end
    end
    m_hilo = ref_commit(o, a, b, m_hilo);
    check("busy_commit", busy, 0);
    check("done_commit", done, 1);
    check("hilo_commit", {hi, lo}, m_hilo);
    tick();
    check("done_pulse", done, 0);
    check("busy_idle", busy, 0);
    check("mul_a_hold", mul_a, a);
    check("mul_b_hold", mul_b, b);
  endtask

  task automatic run_mt(input bit to_lo, input logic [31:0] v);
    op = to_lo ? 3'b101 : 3'b100; rs_val = v; rt_val = $urandom; flush = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    if (to_lo) m_hilo[31:0] = v;
    else       m_hilo[63:32] = v;
    check("hilo_mt", {hi, lo}, m_hilo);
    check("busy_mt", busy, 0);
    check("done_mt", done, 0);
  endtask

  // start that must be ignored: flushed in IDLE or reserved opcode.
  task automatic run_ignored(input logic [2:0] o, input bit fl);
    op = o; rs_val = $urandom; rt_val = $urandom; flush = fl; start = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("busy_ignored", busy, 0);
    check("hilo_ignored", {hi, lo}, m_hilo);
    tick();
    check("busy_ignored2", busy, 0);
    check("done_ignored", done, 0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'b000; rs_val = '0; rt_val = '0; flush = 1'b0;
    m_hilo = '0;
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_mul_ab", {mul_a, mul_b}, 64'd0);
    tick();
    reset = 1'b1;
    tick();

    // Directed cases
    run_mul(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 0, 1'b0);
    check("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_mul(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    check("multu_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_mul(3'd0, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);
    check("mult_min_const", {hi, lo}, 64'h4000_0000_0000_0000);
    run_mt(1'b0, 32'd5);
    run_mt(1'b1, 32'd7);
    run_mul(3'd2, 32'd2, 32'd3, 0, 1'b0);
    check("madd_const", {hi, lo}, 64'h0000_0005_0000_000D);
    run_mul(3'd3, 32'd1, 32'hE, 0, 1'b0);
    check("msub_const", {hi, lo}, 64'h0000_0004_FFFF_FFFF);
    run_mul(3'd0, 32'd7, 32'd9, 2, 1'b1);
    check("flush_keeps_hilo", {hi, lo}, 64'h0000_0004_FFFF_FFFF);
    run_mul(3'd2, 32'd7, 32'd9, LAT, 1'b0);
    run_ignored(3'd0, 1'b1);
    run_ignored(3'd6, 1'b0);
    run_ignored(3'd7, 1'b0);

    // Reset asserted mid-WAIT after a commit
    run_mul(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b0);
    op = 3'd0; rs_val = 32'h1111_1111; rt_val = 32'h2222_2222; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 reset = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_hilo", {hi, lo}, 64'd0);
    check("arst_mul_ab", {mul_a, mul_b}, 64'd0);
    #1 reset = 1'b1;
    m_hilo = '0;
    tick();
    run_mul(3'd0, 32'd2, 32'd2, 0, 1'b0);
    check("post_reset_lo", lo, 64'd4);

    // Randomized operation mix
    for (int i = 0; i < 300; i++) begin
      int unsigned sel;
      sel = $urandom_range(0, 19);
      if (sel < 14) begin
        run_mul(3'($urandom_range(0, 3)), rand_operand(), rand_operand(),
                ($urandom_range(0, 7) == 0) ? $urandom_range(1, LAT) : 0,
                1'($urandom_range(0, 1)));
      end else if (sel < 18) begin
        run_mt(1'($urandom_range(0, 1)), $urandom);
      end else if (sel == 18) begin
        run_ignored(3'($urandom_range(0, 5)), 1'b1);
      end else begin
        run_ignored(3'($urandom_range(6, 7)), 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hilo_mul_ctrl.md
# hilo_mul_ctrl

Multiply-unit controller for the MIPS core's HI/LO datapath. Accepts MULT/MULTU/MADD/MSUB/MTHI/MTLO from the EX stage and registers the operands onto the combinational 32x32 signed multiplier. It holds them for a fixed multicycle window, corrects the signed product for unsigned ops, accumulates where required, and commits to the architectural HI/LO registers. It raises `busy` so the pipeline stalls, and supports flush of an in-flight operation on exception.

## Interface
- `LATENCY`, 3: cycles operands are held on the multiplier before the product is sampled (multicycle path budget); legal range 1..15.
- `clk`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; low forces all state to reset values immediately.
- `start`  in  1  one-cycle request from EX; sampled only in IDLE.
- `op`  in  3  000 MULT, 001 MULTU, 010 MADD, 011 MSUB, 100 MTHI, 101 MTLO; 110/111 ignored (no state change).
- `rs_val`  in  32  operand A / MTHI-MTLO source.
- `rt_val`  in  32  operand B.
- `flush`  in  1  kill any accepted, uncommitted multiply.
- `mul_a`  out  32  registered operand to multiplier `a`.
- `mul_b`  out  32  registered operand to multiplier `b`.
- `mul_z`  in  64  signed product from multiplier.
- `busy`  out  1  registered; high while a multiply is in flight.
- `done`  out  1  registered one-cycle pulse after a multiply commits.
- `hi`  out  32  architectural HI.
- `lo`  out  32  architectural LO.

## Operation
- States: IDLE, WAIT. Reset: IDLE, `busy`=0, `done`=0, `mul_a`=`mul_b`=0, `hi`=`lo`=0, counter=0.
- IDLE, `start`=1, `flush`=0, op MULT/MULTU/MADD/MSUB: latch `rs_val`→`mul_a`, `rt_val`→`mul_b`, latch op, counter←LATENCY, go WAIT.
- IDLE, `start`=1, `flush`=0, op MTHI/MTLO: write `rs_val` into `hi`/`lo` at that edge; stay IDLE; no `busy`, no `done`.
- IDLE, `flush`=1: `start` ignored.
- WAIT: counter decrements each cycle; on the cycle counter==1 with `flush`=0, commit at that edge, go IDLE, `done`←1 for one cycle.
- WAIT, `flush`=1 (any cycle, including counter==1): go IDLE, no commit, no `done`; `hi`/`lo` unchanged.
- `start` while in WAIT is ignored; EX must hold the instruction while `busy`.
- `mul_a`/`mul_b` hold their last values in IDLE (no toggling).
- Commit arithmetic, all mod 2^64, `a`=`mul_a`, `b`=`mul_b` as unsigned, Ps=`mul_z`:
  - MULT: {hi,lo} ← Ps.
  - MULTU: {hi,lo} ← Ps + (((a[31]?b:0) + (b[31]?a:0)) << 32).
  - MADD: {hi,lo} ← {hi,lo} + Ps.
  - MSUB: {hi,lo} ← {hi,lo} − Ps.
- Accumulate ops use `hi`/`lo` as they stand at commit time.

## Timing
- Start accepted at cycle T (edge ending T). `busy`=1 in cycles T+1..T+LATENCY; commit on edge ending T+LATENCY; new `hi`/`lo` and `done`=1 visible in T+LATENCY+1, `busy`=0 there.
- Next `start` accepted earliest in T+LATENCY+1 (back-to-back throughput LATENCY+1 cycles).
- MTHI/MTLO: value visible at T+1.
- `reset` low at any time, including mid-WAIT: outputs return to reset values asynchronously; first accept possible on the first rising edge after release.

## Test plan
- MULT rs=0xFFFFFFFE, rt=0x00000003, LATENCY=3 → `busy` high T+1..T+3, `done` at T+4, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0x00000000.
- MTHI 5, MTLO 7, MADD 2×3 → hi=0x5, lo=0xD; then MSUB 1×0xE → hi=0x4, lo=0xFFFFFFFF.
- MULT 7×9 with `flush` at T+2, plus second `start` at T+1 → `busy` low at T+3, no `done`, hi/lo unchanged, second start dropped.
- `flush` exactly at counter==1 cycle → no commit; `flush` with `start` in IDLE → nothing accepted.
- `reset` driven low mid-WAIT after a prior commit → `busy`, `done`, `hi`, `lo`, `mul_a`, `mul_b` all 0 before next clock edge; post-release MULT 2×2 → lo=4.
